// File: rtl/timer_mic.sv
// timer_mic: microwave-oven MM:SS countdown timer with keypad entry and a run/pause/done FSM.
// Latency: every input strobe takes effect on the next clk rising edge; tend rises the cycle after the time reaches 00:00.
// Backpressure: none; strobes are single-cycle, and a strobe that is not accepted in that cycle is dropped.
//
// Ports:
//   clk, rst_n                   clock and async active-low reset
//   tick                         1 Hz count-enable strobe (acts only in RUN)
//   key_valid, key_digit[3:0]    keypad digit strobe (digits 0-9 only)
//   start, pause, clear          "Ligar", pause and "Cancela" strobes
//   add30                        "+30 s" strobe, present only when TIMER_MIC_ADD30_EN is defined
//   min_t, min_o, sec_t, sec_o   BCD time digits MM:SS
//   running, tend                state decodes: RUN, and DONE (end of count)
//
// Optional feature macro: TIMER_MIC_ADD30_EN (adds the add30 port and its logic).
module timer_mic (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       key_valid,
   input  logic [3:0] key_digit,
   input  logic       start,
   input  logic       pause,
   input  logic       clear,
`ifdef TIMER_MIC_ADD30_EN
   input  logic       add30,
`endif
   output logic [3:0] min_t,
   output logic [3:0] min_o,
   output logic [3:0] sec_t,
   output logic [3:0] sec_o,
   output logic       running,
   output logic       tend
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t     state, state_nxt;
   logic [3:0] min_t_nxt, min_o_nxt, sec_t_nxt, sec_o_nxt;

   logic key_ok;
   logic time_nz;

   // +30 s result, computed separately so the priority chain below stays flat
   logic       add30_hit;
   logic       add30_to_run;
   logic [3:0] a30_min_t, a30_min_o, a30_sec_t, a30_sec_o;

   assign key_ok  = key_valid && (key_digit <= 4'd9);
   assign time_nz = (min_t != 4'd0) || (min_o != 4'd0) || (sec_t != 4'd0) || (sec_o != 4'd0);

`ifdef TIMER_MIC_ADD30_EN
   logic [6:0] sec_bin;
   logic [6:0] sec_new;
   logic       min_carry;
   logic [6:0] sec_new_t;
   logic [6:0] sec_new_o;

   always_comb begin
      add30_hit    = 1'b0;
      add30_to_run = 1'b0;
      a30_min_t    = min_t;
      a30_min_o    = min_o;
      a30_sec_t    = sec_t;
      a30_sec_o    = sec_o;

      // Seconds may hold up to 99 as entered, so work in binary and convert back
      sec_bin   = ({3'd0, sec_t} * 7'd10) + {3'd0, sec_o};
      min_carry = (sec_bin >= 7'd30);
      sec_new   = min_carry ? (sec_bin - 7'd30) : (sec_bin + 7'd30);
      sec_new_t = sec_new / 7'd10;
      sec_new_o = sec_new % 7'd10;

      if (add30 && (state != DONE)) begin
         if ((state == IDLE) && !time_nz) begin
            // Quick start from an empty display: 00:30 and go
            add30_hit    = 1'b1;
            add30_to_run = 1'b1;
            a30_sec_t    = 4'd3;
            a30_sec_o    = 4'd0;
         end else if (!(min_carry && (min_t == 4'd9) && (min_o == 4'd9))) begin
            add30_hit = 1'b1;
            a30_sec_t = sec_new_t[3:0];
            a30_sec_o = sec_new_o[3:0];
            if (min_carry) begin
               if (min_o == 4'd9) begin
                  a30_min_o = 4'd0;
                  a30_min_t = min_t + 4'd1;
               end else begin
                  a30_min_o = min_o + 4'd1;
               end
            end
         end
      end
   end
`else
   assign add30_hit    = 1'b0;
   assign add30_to_run = 1'b0;
   assign a30_min_t    = 4'd0;
   assign a30_min_o    = 4'd0;
   assign a30_sec_t    = 4'd0;
   assign a30_sec_o    = 4'd0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         min_t <= 4'd0;
         min_o <= 4'd0;
         sec_t <= 4'd0;
         sec_o <= 4'd0;
      end else begin
         state <= state_nxt;
         min_t <= min_t_nxt;
         min_o <= min_o_nxt;
         sec_t <= sec_t_nxt;
         sec_o <= sec_o_nxt;
      end
   end

   // Only the highest-priority event that actually applies in the current
   // state acts; an inapplicable strobe does not mask lower-priority events.
   always_comb begin
      state_nxt = state;
      min_t_nxt = min_t;
      min_o_nxt = min_o;
      sec_t_nxt = sec_t;
      sec_o_nxt = sec_o;

      if (clear) begin
         state_nxt = IDLE;
         min_t_nxt = 4'd0;
         min_o_nxt = 4'd0;
         sec_t_nxt = 4'd0;
         sec_o_nxt = 4'd0;
      end else if (start && (((state == IDLE) && time_nz) || (state == PAUSE))) begin
         // Any tick in this cycle is swallowed: counting begins on the next tick
         state_nxt = RUN;
      end else if (pause && (state == RUN)) begin
         state_nxt = PAUSE;
      end else if (add30_hit) begin
         min_t_nxt = a30_min_t;
         min_o_nxt = a30_min_o;
         sec_t_nxt = a30_sec_t;
         sec_o_nxt = a30_sec_o;
         if (add30_to_run) begin
            state_nxt = RUN;
         end
      end else if (key_ok && ((state == IDLE) || (state == DONE))) begin
         state_nxt = IDLE;
         min_t_nxt = min_o;
         min_o_nxt = sec_t;
         sec_t_nxt = sec_o;
         sec_o_nxt = key_digit;
      end else if (state == RUN) begin
         if (!time_nz) begin
            // The tick that reached 00:00 left us in RUN; finish one cycle later
            state_nxt = DONE;
         end else if (tick) begin
            if (sec_o != 4'd0) begin
               sec_o_nxt = sec_o - 4'd1;
            end else if (sec_t != 4'd0) begin
               sec_o_nxt = 4'd9;
               sec_t_nxt = sec_t - 4'd1;
            end else begin
               // Seconds exhausted, minutes are known nonzero here
               sec_t_nxt = 4'd5;
               sec_o_nxt = 4'd9;
               if (min_o != 4'd0) begin
                  min_o_nxt = min_o - 4'd1;
               end else begin
                  min_o_nxt = 4'd9;
                  min_t_nxt = min_t - 4'd1;
               end
            end
         end
      end
   end

   assign running = (state == RUN);
   assign tend    = (state == DONE);

endmodule

// File: tb/tb_timer_mic.sv
// tb_timer_mic: directed-vector bench for timer_mic with hand-computed MM:SS expectations.
// Latency: inputs are driven 1 ns after a rising edge and outputs sampled 1 ns after the next one.
// Backpressure: none; every strobe is held for exactly one cycle.
module tb_timer_mic;

   logic       clk;
   logic       rst_n;
   logic       tick;
   logic       key_valid;
   logic [3:0] key_digit;
   logic       start;
   logic       pause;
   logic       clear;
`ifdef TIMER_MIC_ADD30_EN
   logic       add30;
`endif
   logic [3:0] min_t, min_o, sec_t, sec_o;
   logic       running;
   logic       tend;

   logic [15:0] tm;
   int          checks;
   int          errors;

   assign tm = {min_t, min_o, sec_t, sec_o};

   timer_mic dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (tick),
      .key_valid (key_valid),
      .key_digit (key_digit),
      .start     (start),
      .pause     (pause),
      .clear     (clear),
`ifdef TIMER_MIC_ADD30_EN
      .add30     (add30),
`endif
      .min_t     (min_t),
      .min_o     (min_o),
      .sec_t     (sec_t),
      .sec_o     (sec_o),
      .running   (running),
      .tend      (tend)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle 1 ns past the edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drop_all();
      tick      = 1'b0;
      key_valid = 1'b0;
      start     = 1'b0;
      pause     = 1'b0;
      clear     = 1'b0;
`ifdef TIMER_MIC_ADD30_EN
      add30     = 1'b0;
`endif
   endtask

   task automatic key(input logic [3:0] d);
      key_valid = 1'b1;
      key_digit = d;
      cyc();
      drop_all();
   endtask

   task automatic do_start();
      start = 1'b1;
      cyc();
      drop_all();
   endtask

   task automatic do_pause();
      pause = 1'b1;
      cyc();
      drop_all();
   endtask

   task automatic do_clear();
      clear = 1'b1;
      cyc();
      drop_all();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick = 1'b1;
         cyc();
         drop_all();
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      key_digit = 4'd0;
      drop_all();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_time", tm, 16'h0000);
      chk("rst_run", {15'd0, running}, 16'd0);
      chk("rst_tend", {15'd0, tend}, 16'd0);
      rst_n = 1'b1;
      cyc();

      // Keys 1,3,0 then start and three ticks
      key(4'd1);
      key(4'd3);
      key(4'd0);
      chk("entry_130", tm, 16'h0130);
      key(4'd12);
      chk("bad_digit", tm, 16'h0130);
      do_pause();
      chk("pause_idle", {15'd0, running}, 16'd0);
      do_start();
      chk("start_run", {15'd0, running}, 16'd1);
      key(4'd7);
      chk("key_in_run", tm, 16'h0130);
      ticks(1);
      chk("tick_borrow", tm, 16'h0129);
      ticks(2);
      chk("three_ticks", tm, 16'h0127);
      chk("three_run", {15'd0, running}, 16'd1);
      chk("three_tend", {15'd0, tend}, 16'd0);
      do_clear();
      chk("clr_time", tm, 16'h0000);
      chk("clr_run", {15'd0, running}, 16'd0);

      // 00:02 down to DONE, then a key leaves DONE
      key(4'd2);
      do_start();
      ticks(1);
      chk("done_t1", tm, 16'h0001);
      ticks(1);
      chk("done_t2", tm, 16'h0000);
      chk("done_t2_run", {15'd0, running}, 16'd1);
      chk("done_t2_tend", {15'd0, tend}, 16'd0);
      cyc();
      chk("done_tend", {15'd0, tend}, 16'd1);
      chk("done_run", {15'd0, running}, 16'd0);
      ticks(2);
      do_start();
      chk("done_hold_t", tm, 16'h0000);
      chk("done_hold", {15'd0, tend}, 16'd1);
      key(4'd5);
      chk("done_key", tm, 16'h0005);
      chk("done_key_tend", {15'd0, tend}, 16'd0);
      chk("done_key_run", {15'd0, running}, 16'd0);
      do_clear();

      // 10:00, minute borrow, pause freezes, resume
      key(4'd1);
      key(4'd0);
      key(4'd0);
      key(4'd0);
      do_start();
      ticks(1);
      chk("min_borrow", tm, 16'h0959);
      do_pause();
      chk("paused_run", {15'd0, running}, 16'd0);
      ticks(5);
      chk("paused_time", tm, 16'h0959);
      do_start();
      chk("resume_run", {15'd0, running}, 16'd1);
      ticks(1);
      chk("resume_tick", tm, 16'h0958);
      do_clear();

      // Start at 00:00 ignored; start+tick same cycle ignores the tick
      do_start();
      chk("start_zero", {15'd0, running}, 16'd0);
      key(4'd9);
      key(4'd9);
      start = 1'b1;
      tick  = 1'b1;
      cyc();
      drop_all();
      chk("start_tick_t", tm, 16'h0099);
      chk("start_tick_r", {15'd0, running}, 16'd1);
      ticks(1);
      chk("sec99_tick", tm, 16'h0098);
      do_clear();

      // Async reset between edges mid-RUN
      key(4'd1);
      key(4'd0);
      key(4'd0);
      do_start();
      ticks(1);
      chk("sec_wrap", tm, 16'h0059);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_time", tm, 16'h0000);
      chk("arst_run", {15'd0, running}, 16'd0);
      rst_n = 1'b1;
      cyc();
      cyc();
      chk("post_rst_t", tm, 16'h0000);
      chk("post_rst_r", {15'd0, running}, 16'd0);

      // clear beats start in PAUSE
      key(4'd5);
      do_start();
      do_pause();
      clear = 1'b1;
      start = 1'b1;
      cyc();
      drop_all();
      chk("clr_start_t", tm, 16'h0000);
      chk("clr_start_r", {15'd0, running}, 16'd0);
      cyc();
      chk("clr_start_r2", {15'd0, running}, 16'd0);

`ifdef TIMER_MIC_ADD30_EN
      add30 = 1'b1;
      cyc();
      drop_all();
      chk("a30_zero_t", tm, 16'h0030);
      chk("a30_zero_r", {15'd0, running}, 16'd1);
      do_clear();
      key(4'd4);
      key(4'd5);
      add30 = 1'b1;
      cyc();
      drop_all();
      chk("a30_carry", tm, 16'h0115);
      chk("a30_carry_r", {15'd0, running}, 16'd0);
      do_clear();
      key(4'd9);
      key(4'd9);
      key(4'd4);
      key(4'd0);
      add30 = 1'b1;
      cyc();
      drop_all();
      chk("a30_ovf", tm, 16'h9940);
      do_clear();
      key(4'd9);
      key(4'd9);
      key(4'd2);
      key(4'd0);
      add30 = 1'b1;
      cyc();
      drop_all();
      chk("a30_nocarry", tm, 16'h9950);
      do_clear();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
